liteic_slave_node_write: RTL and testbench
==========================================

# liteic_slave_node_write

Write-path slave node of the lite interconnect: one instance per slave slot, sitting directly downstream of the crossbar matrix that the master write nodes drive. It collects AW/W requests from all master nodes, grants one master at a time with a round-robin arbiter, forwards that master's address and data to the slave's AXI-Lite port, and routes the B response back to the granted master only. It is single-outstanding: a new grant is issued only after the current B handshake completes.

## Interface
- IC_NUM_MASTER_SLOTS: default from liteic_pkg (4). Number of master nodes feeding this slave.
- IC_AWADDR_WIDTH: default from liteic_pkg (32). AW payload width.
- IC_WDATA_WIDTH: default from liteic_pkg (36). W payload width, packed as {w_strb, w_data}.
- IC_BRESP_WIDTH: default from liteic_pkg (2). B response width.

Ports:
- clk_i  in  1  single clock.
- rstn_i  in  1  asynchronous, active-low reset.
- cbar_aw_reqst_val_i  in  IC_NUM_MASTER_SLOTS  per-master AW valid.
- cbar_aw_reqst_rdy_o  out  IC_NUM_MASTER_SLOTS  per-master AW ready.
- cbar_aw_reqst_data_i  in  IC_AWADDR_WIDTH x IC_NUM_MASTER_SLOTS (unpacked)  per-master address.
- cbar_w_reqst_val_i  in  IC_NUM_MASTER_SLOTS  per-master W valid.
- cbar_w_reqst_rdy_o  out  IC_NUM_MASTER_SLOTS  per-master W ready.
- cbar_w_reqst_data_i  in  IC_WDATA_WIDTH x IC_NUM_MASTER_SLOTS (unpacked)  per-master {strb,data}.
- cbar_resp_val_o  out  IC_NUM_MASTER_SLOTS  per-master B valid.
- cbar_resp_rdy_i  in  IC_NUM_MASTER_SLOTS  per-master B ready.
- cbar_resp_data_o  out  IC_BRESP_WIDTH  B response, broadcast to all masters.
- slv_axil  axi_lite_if  —  slave-side AXI-Lite port. The block drives aw_*, w_*, b_ready; it samples aw_ready, w_ready, b_valid, b_resp.

## Operation
- FSM states: IDLE, XFER, RESP.
- IDLE:
  - If any cbar_aw_reqst_val_i bit is set, the arbiter picks the first requester at or after rr_ptr (wrapping modulo IC_NUM_MASTER_SLOTS).
  - grant_r <= one-hot of that requester; go to XFER.
  - No ready or valid is driven in IDLE.
  - W valid alone never triggers a grant.
- XFER: AW and W are combinational pass-through for the granted master g.
  - slv aw_valid = val_i[g] && !aw_done_r.
  - slv aw_addr = data_i[g].
  - cbar_aw_reqst_rdy_o[g] = slv aw_ready && !aw_done_r.
  - W channel follows the same pattern with w_done_r; w_strb and w_data are unpacked from the payload.
  - aw_done_r / w_done_r are set on their respective handshakes.
  - Go to RESP when both are done, counting handshakes in the current cycle.
  - W may complete before, after, or in the same cycle as AW.
- RESP:
  - slv b_ready = cbar_resp_rdy_i[g].
  - cbar_resp_val_o[g] = slv b_valid.
  - cbar_resp_data_o = slv b_resp, held continuously.
  - On the B handshake: clear grant_r, aw_done_r and w_done_r; set rr_ptr <= (g+1) mod N; go to IDLE.
- Outputs toward non-granted masters are always 0. Their requests remain pending and are not dropped.
- slv b_valid outside RESP is ignored (b_ready = 0).
- Reset: state IDLE, rr_ptr = 0, grant_r = 0, done flags = 0.
  - All val and rdy outputs are 0; cbar_resp_data_o is 0 when not in RESP.
  - Reset mid-transaction abandons it silently.

## Timing
- AW-valid-to-slave latency: 1 cycle (arbitration is registered in IDLE).
- AW/W/B data paths within XFER and RESP are zero-latency combinational.
- Minimum transaction: 3 cycles (IDLE, XFER with both handshakes, RESP with immediate B).
- Back-to-back: after the B handshake in cycle t, IDLE in t+1 and the next grant takes effect in t+2.
- Fairness: a continuously requesting master waits at most N-1 transactions.

## Structure
- liteic_pkg holds IC_NUM_MASTER_SLOTS, the widths, and an enum typedef for the FSM state (ic_slv_node_st_t).
- Sub-module liteic_rr_arbiter:
  - Parameter N.
  - Inputs: req[N] and ptr (clog2 width).
  - Output: gnt one-hot.
  - Purely combinational; reusable by the read slave node.

## Test plan
- Single master: master 2 sends AW=0x1000_0040 and W={4'hF, 32'hDEAD_BEEF}; slave responds OKAY → slave sees that address and data; cbar_resp_val_o = 4'b0100 with resp 2'b00; rr_ptr = 3.
- W before AW: master 0 asserts W 3 cycles ahead of AW → W stalls until grant, then both complete; a single B is returned to master 0.
- Contention: masters 0, 1 and 3 request simultaneously from reset → grants issued in order 0, 1, 3; repeat with all requesting → order 0, 1, 2, 3, 0.
- Backpressure: slave holds aw_ready = 0 for 5 cycles with w_ready = 1 → W completes first, AW completes after 5 cycles, then RESP; no extra handshakes.
- Response stall: master holds b_ready low for 4 cycles while slave b_valid = 1 and b_resp = SLVERR → SLVERR is stable on cbar_resp_data_o and slave b_ready stays 0 until the master accepts.
- Reset in XFER: assert rstn_i low after the AW handshake, before W → all outputs 0 immediately; after release, a new request is granted to master 0.

Source files
------------

// File: rtl/liteic_pkg.sv
// liteic_pkg: shared parameters and types for the lite interconnect.
//   IC_NUM_MASTER_SLOTS : number of master nodes feeding each slave node
//   IC_AWADDR_WIDTH     : AW payload width
//   IC_DATA_WIDTH       : raw write-data width (without strobes)
//   IC_WSTRB_WIDTH      : byte-strobe width
//   IC_WDATA_WIDTH      : W payload width, packed as {w_strb, w_data}
//   IC_BRESP_WIDTH      : B response width
//   ic_slv_node_st_t    : slave-node FSM state
package liteic_pkg;

    localparam int IC_NUM_MASTER_SLOTS = 4;
    localparam int IC_AWADDR_WIDTH     = 32;
    localparam int IC_DATA_WIDTH       = 32;
    localparam int IC_WSTRB_WIDTH      = IC_DATA_WIDTH / 8;
    localparam int IC_WDATA_WIDTH      = IC_DATA_WIDTH + IC_WSTRB_WIDTH;
    localparam int IC_BRESP_WIDTH      = 2;

    typedef enum logic [1:0] {
        IC_SLV_IDLE = 2'd0,
        IC_SLV_XFER = 2'd1,
        IC_SLV_RESP = 2'd2
    } ic_slv_node_st_t;

endpackage

// File: rtl/axi_lite_if.sv
// axi_lite_if: write channels of an AXI-Lite link.
//   master modport : drives aw_*, w_*, b_ready; samples aw_ready, w_ready, b_valid, b_resp
//   slave modport  : the opposite direction
// Handshake rule on every channel: a beat transfers in a cycle where valid and
// ready are both high at the rising clock edge; valid never waits on ready.
interface axi_lite_if #(
    parameter int ADDR_W = liteic_pkg::IC_AWADDR_WIDTH,
    parameter int DATA_W = liteic_pkg::IC_DATA_WIDTH,
    parameter int RESP_W = liteic_pkg::IC_BRESP_WIDTH
);
    logic [ADDR_W-1:0]   aw_addr;
    logic                aw_valid;
    logic                aw_ready;
    logic [DATA_W-1:0]   w_data;
    logic [DATA_W/8-1:0] w_strb;
    logic                w_valid;
    logic                w_ready;
    logic [RESP_W-1:0]   b_resp;
    logic                b_valid;
    logic                b_ready;

    modport master (
        output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
        input  aw_ready, w_ready, b_resp, b_valid
    );

    modport slave (
        input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
        output aw_ready, w_ready, b_resp, b_valid
    );
endinterface

// File: rtl/liteic_rr_arbiter.sv
// liteic_rr_arbiter: combinational round-robin pick.
//   req_i : per-requester request bits
//   ptr_i : index with highest priority this round
//   gnt_o : one-hot grant of the first requester at or after ptr_i (wrapping), 0 if none
module liteic_rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o
);
    logic found;
    int   idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_i) + i) % N;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/liteic_slave_node_write.sv
// liteic_slave_node_write: write-path slave node, one per slave slot.
//   clk_i, rstn_i          : clock, asynchronous active-low reset
//   cbar_aw_reqst_*        : per-master AW valid/ready/address from the crossbar
//   cbar_w_reqst_*         : per-master W valid/ready/{strb,data} from the crossbar
//   cbar_resp_val_o/rdy_i  : per-master B valid/ready; cbar_resp_data_o is broadcast
//   slv_axil               : AXI-Lite write port toward the slave
// One master is granted at a time (round robin over AW requests); only one
// transaction is outstanding, the next grant follows the B handshake.
module liteic_slave_node_write #(
    parameter int IC_NUM_MASTER_SLOTS = liteic_pkg::IC_NUM_MASTER_SLOTS,
    parameter int IC_AWADDR_WIDTH     = liteic_pkg::IC_AWADDR_WIDTH,
    parameter int IC_WDATA_WIDTH      = liteic_pkg::IC_WDATA_WIDTH,
    parameter int IC_BRESP_WIDTH      = liteic_pkg::IC_BRESP_WIDTH
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic [IC_NUM_MASTER_SLOTS-1:0] cbar_aw_reqst_val_i,
    output logic [IC_NUM_MASTER_SLOTS-1:0] cbar_aw_reqst_rdy_o,
    input  logic [IC_AWADDR_WIDTH-1:0]     cbar_aw_reqst_data_i [IC_NUM_MASTER_SLOTS],
    input  logic [IC_NUM_MASTER_SLOTS-1:0] cbar_w_reqst_val_i,
    output logic [IC_NUM_MASTER_SLOTS-1:0] cbar_w_reqst_rdy_o,
    input  logic [IC_WDATA_WIDTH-1:0]      cbar_w_reqst_data_i [IC_NUM_MASTER_SLOTS],
    output logic [IC_NUM_MASTER_SLOTS-1:0] cbar_resp_val_o,
    input  logic [IC_NUM_MASTER_SLOTS-1:0] cbar_resp_rdy_i,
    output logic [IC_BRESP_WIDTH-1:0]      cbar_resp_data_o,
    axi_lite_if.master                     slv_axil
);
    import liteic_pkg::*;

    localparam int N      = IC_NUM_MASTER_SLOTS;
    localparam int PTR_W  = (N > 1) ? $clog2(N) : 1;
    // {strb, data} with one strobe per byte: strobe width is 1/9 of the payload
    localparam int STRB_W = IC_WDATA_WIDTH / 9;
    localparam int DATA_W = IC_WDATA_WIDTH - STRB_W;

    ic_slv_node_st_t     state_q;
    logic [N-1:0]        grant_q;
    logic [PTR_W-1:0]    gidx_q;
    logic [PTR_W-1:0]    rr_ptr_q;
    logic [PTR_W-1:0]    rr_ptr_d;
    logic                aw_done_q;
    logic                w_done_q;

    logic [N-1:0]        arb_gnt;
    logic [PTR_W-1:0]    arb_idx;

    logic                aw_valid;
    logic                w_valid;
    logic                b_ready;
    logic [IC_AWADDR_WIDTH-1:0] aw_addr;
    logic [IC_WDATA_WIDTH-1:0]  w_payload;
    logic                aw_hs;
    logic                w_hs;
    logic                b_hs;

    liteic_rr_arbiter #(
        .N     (N),
        .PTR_W (PTR_W)
    ) u_arb (
        .req_i (cbar_aw_reqst_val_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt)
    );

    // Binary index of the one-hot grant, kept alongside grant_q for muxing.
    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (arb_gnt[i]) begin
                arb_idx = PTR_W'(i);
            end
        end
    end

    // Pass-through of the granted master; everything else stays 0.
    always_comb begin
        cbar_aw_reqst_rdy_o = '0;
        cbar_w_reqst_rdy_o  = '0;
        cbar_resp_val_o     = '0;
        cbar_resp_data_o    = '0;
        aw_valid            = 1'b0;
        w_valid             = 1'b0;
        b_ready             = 1'b0;
        aw_addr             = '0;
        w_payload           = '0;
        case (state_q)
            IC_SLV_XFER: begin
                aw_valid            = cbar_aw_reqst_val_i[gidx_q] && !aw_done_q;
                aw_addr             = cbar_aw_reqst_data_i[gidx_q];
                cbar_aw_reqst_rdy_o = grant_q & {N{slv_axil.aw_ready && !aw_done_q}};
                w_valid             = cbar_w_reqst_val_i[gidx_q] && !w_done_q;
                w_payload           = cbar_w_reqst_data_i[gidx_q];
                cbar_w_reqst_rdy_o  = grant_q & {N{slv_axil.w_ready && !w_done_q}};
            end
            IC_SLV_RESP: begin
                b_ready          = cbar_resp_rdy_i[gidx_q];
                cbar_resp_val_o  = grant_q & {N{slv_axil.b_valid}};
                cbar_resp_data_o = slv_axil.b_resp;
            end
            default: begin
            end
        endcase
    end

    assign slv_axil.aw_valid = aw_valid;
    assign slv_axil.aw_addr  = aw_addr;
    assign slv_axil.w_valid  = w_valid;
    assign slv_axil.w_strb   = w_payload[IC_WDATA_WIDTH-1 -: STRB_W];
    assign slv_axil.w_data   = w_payload[DATA_W-1:0];
    assign slv_axil.b_ready  = b_ready;

    assign aw_hs = aw_valid && slv_axil.aw_ready;
    assign w_hs  = w_valid && slv_axil.w_ready;
    assign b_hs  = b_ready && slv_axil.b_valid;

    // Priority moves to the master just after the one served.
    assign rr_ptr_d = (gidx_q == PTR_W'(N - 1)) ? '0 : gidx_q + PTR_W'(1);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IC_SLV_IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            rr_ptr_q  <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            case (state_q)
                IC_SLV_IDLE: begin
                    // Only AW requests arbitrate; a lone W waits for its AW.
                    if (|cbar_aw_reqst_val_i) begin
                        grant_q   <= arb_gnt;
                        gidx_q    <= arb_idx;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        state_q   <= IC_SLV_XFER;
                    end
                end
                IC_SLV_XFER: begin
                    if (aw_hs) aw_done_q <= 1'b1;
                    if (w_hs)  w_done_q  <= 1'b1;
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                        state_q <= IC_SLV_RESP;
                    end
                end
                IC_SLV_RESP: begin
                    if (b_hs) begin
                        grant_q   <= '0;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        rr_ptr_q  <= rr_ptr_d;
                        state_q   <= IC_SLV_IDLE;
                    end
                end
                default: begin
                    state_q <= IC_SLV_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_liteic_slave_node_write.sv
module tb_liteic_slave_node_write;
    import liteic_pkg::*;

    localparam int N  = IC_NUM_MASTER_SLOTS;
    localparam int AW = IC_AWADDR_WIDTH;
    localparam int WW = IC_WDATA_WIDTH;
    localparam int BW = IC_BRESP_WIDTH;
    localparam int TW = 8 + AW + WW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [N-1:0]  aw_val, aw_rdy, w_val, w_rdy, resp_val, resp_rdy;
    logic [AW-1:0] aw_data [N];
    logic [WW-1:0] w_data  [N];
    logic [BW-1:0] resp_data;

    axi_lite_if slv ();

    liteic_slave_node_write dut (
        .clk_i                (clk),
        .rstn_i               (rstn),
        .cbar_aw_reqst_val_i  (aw_val),
        .cbar_aw_reqst_rdy_o  (aw_rdy),
        .cbar_aw_reqst_data_i (aw_data),
        .cbar_w_reqst_val_i   (w_val),
        .cbar_w_reqst_rdy_o   (w_rdy),
        .cbar_w_reqst_data_i  (w_data),
        .cbar_resp_val_o      (resp_val),
        .cbar_resp_rdy_i      (resp_rdy),
        .cbar_resp_data_o     (resp_data),
        .slv_axil             (slv)
    );

    // ---------------- bench state ----------------
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit rnd_mode = 1'b0;

    // master side
    bit m_aw_pend [N];
    bit m_w_pend  [N];
    bit m_wait_b  [N];
    int m_aw_dly  [N];
    int m_w_dly   [N];
    int m_brdy_block [N];
    int b_count   [N];
    logic [N-1:0]  last_resp_vec;
    logic [BW-1:0] last_resp_dat;

    // slave side
    int s_aw_block, s_w_block, s_b_dly;
    bit s_aw_seen, s_w_seen, s_bhs;
    logic [BW-1:0] s_resp_next;
    logic [AW-1:0] s_addr;
    logic [WW-1:0] s_wpay;
    int s_aw_cnt, s_w_cnt, s_b_cnt, s_aw_cyc, s_w_cyc, s_b_cyc;

    // reference model: transaction-level view of the node
    bit md_busy, md_resp, md_aw_done, md_w_done;
    int md_g, md_ptr;
    logic [TW-1:0] exp_q[$];
    int grant_log[$];

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
        for (int i = 0; i < N; i++) begin
            if (req[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    function automatic bit tb_idle();
        bit busy;
        busy = md_busy || s_aw_seen || s_w_seen || slv.b_valid;
        for (int m = 0; m < N; m++) busy = busy || m_wait_b[m];
        return !busy;
    endfunction

    // ---------------- drivers ----------------
    task automatic new_req(input int m, input logic [AW-1:0] a, input logic [WW-1:0] w,
                           input int ad, input int wd);
        aw_data[m]   = a;
        w_data[m]    = w;
        m_aw_pend[m] = 1'b1;
        m_w_pend[m]  = 1'b1;
        m_wait_b[m]  = 1'b1;
        m_aw_dly[m]  = ad;
        m_w_dly[m]   = wd;
        aw_val[m]    = (ad == 0);
        w_val[m]     = (wd == 0);
    endtask

    task automatic rand_req(input int m);
        logic [AW-1:0] a;
        logic [WW-1:0] w;
        a = AW'($urandom());
        w = {4'($urandom_range(0, 15)), 32'($urandom())};
        new_req(m, a, w, $urandom_range(0, 3), $urandom_range(0, 3));
    endtask

    task automatic drive();
        for (int m = 0; m < N; m++) begin
            if (m_aw_dly[m] > 0) m_aw_dly[m]--;
            if (m_w_dly[m] > 0)  m_w_dly[m]--;
            aw_val[m] = m_aw_pend[m] && (m_aw_dly[m] == 0);
            w_val[m]  = m_w_pend[m] && (m_w_dly[m] == 0);
            if (m_brdy_block[m] > 0) begin
                resp_rdy[m] = 1'b0;
                m_brdy_block[m]--;
            end else begin
                resp_rdy[m] = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (rnd_mode && !m_wait_b[m] && $urandom_range(0, 3) == 0) rand_req(m);
        end
        if (s_aw_block > 0) begin
            slv.aw_ready = 1'b0;
            s_aw_block--;
        end else begin
            slv.aw_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (s_w_block > 0) begin
            slv.w_ready = 1'b0;
            s_w_block--;
        end else begin
            slv.w_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (s_bhs) begin
            slv.b_valid = 1'b0;
            slv.b_resp  = '0;
            s_bhs       = 1'b0;
        end else if (s_aw_seen && s_w_seen && !slv.b_valid) begin
            if (s_b_dly > 0) begin
                s_b_dly--;
            end else begin
                slv.b_valid = 1'b1;
                slv.b_resp  = s_resp_next;
            end
        end
    endtask

    // One clock cycle: check outputs against the model at the falling edge,
    // record handshakes, advance the model, then drive the next inputs.
    task automatic tick();
        logic          exp_awv, exp_wv, exp_br;
        logic [N-1:0]  exp_awr, exp_wr, exp_rv;
        logic [BW-1:0] exp_rd;
        logic [TW-1:0] t;
        @(negedge clk);
        cyc++;
        exp_awv = 1'b0; exp_wv = 1'b0; exp_br = 1'b0;
        exp_awr = '0;   exp_wr = '0;   exp_rv = '0; exp_rd = '0;
        if (md_busy && !md_resp) begin
            exp_awv       = aw_val[md_g] && !md_aw_done;
            exp_awr[md_g] = slv.aw_ready && !md_aw_done;
            exp_wv        = w_val[md_g] && !md_w_done;
            exp_wr[md_g]  = slv.w_ready && !md_w_done;
        end else if (md_busy && md_resp) begin
            exp_br       = resp_rdy[md_g];
            exp_rv[md_g] = slv.b_valid;
            exp_rd       = slv.b_resp;
        end
        check("slv_aw_valid", slv.aw_valid, exp_awv);
        check("cbar_aw_rdy", aw_rdy, exp_awr);
        check("slv_w_valid", slv.w_valid, exp_wv);
        check("cbar_w_rdy", w_rdy, exp_wr);
        check("slv_b_ready", slv.b_ready, exp_br);
        check("cbar_resp_val", resp_val, exp_rv);
        check("cbar_resp_data", resp_data, exp_rd);
        if (exp_awv) check("slv_aw_addr", slv.aw_addr, aw_data[md_g]);
        if (exp_wv)  check("slv_w_payload", {slv.w_strb, slv.w_data}, w_data[md_g]);

        for (int m = 0; m < N; m++) begin
            if (aw_val[m] && aw_rdy[m]) begin
                m_aw_pend[m] = 1'b0;
                grant_log.push_back(m);
            end
            if (w_val[m] && w_rdy[m]) m_w_pend[m] = 1'b0;
            if (resp_val[m] && resp_rdy[m]) begin
                b_count[m]++;
                m_wait_b[m]   = 1'b0;
                last_resp_vec = resp_val;
                last_resp_dat = resp_data;
                check("b_resp_value", resp_data, slv.b_resp);
                if (exp_q.size() > 0) begin
                    t = exp_q[0];
                    check("b_route", m, t[TW-1 -: 8]);
                end else begin
                    check("b_unexpected", 1, 0);
                end
            end
        end
        if (slv.aw_valid && slv.aw_ready) begin
            s_aw_seen = 1'b1; s_addr = slv.aw_addr; s_aw_cnt++; s_aw_cyc = cyc;
        end
        if (slv.w_valid && slv.w_ready) begin
            s_w_seen = 1'b1; s_wpay = {slv.w_strb, slv.w_data}; s_w_cnt++; s_w_cyc = cyc;
        end
        if (slv.b_valid && slv.b_ready) begin
            s_b_cnt++;
            s_b_cyc = cyc;
            if (exp_q.size() > 0) begin
                t = exp_q.pop_front();
                check("txn_addr", s_addr, t[AW+WW-1 -: AW]);
                check("txn_wdata", s_wpay, t[WW-1:0]);
            end else begin
                check("txn_extra", 1, 0);
            end
            s_aw_seen = 1'b0;
            s_w_seen  = 1'b0;
            s_bhs     = 1'b1;
            s_b_dly   = rnd_mode ? $urandom_range(0, 3) : 0;
            if (rnd_mode) s_resp_next = BW'($urandom_range(0, 3));
        end

        if (!md_busy) begin
            if (|aw_val) begin
                md_g       = rr_pick(aw_val, md_ptr);
                md_busy    = 1'b1;
                md_resp    = 1'b0;
                md_aw_done = 1'b0;
                md_w_done  = 1'b0;
                exp_q.push_back({8'(md_g), aw_data[md_g], w_data[md_g]});
            end
        end else if (!md_resp) begin
            if (exp_awv && slv.aw_ready) md_aw_done = 1'b1;
            if (exp_wv && slv.w_ready)   md_w_done  = 1'b1;
            if (md_aw_done && md_w_done) md_resp = 1'b1;
        end else if (slv.b_valid && resp_rdy[md_g]) begin
            md_busy = 1'b0;
            md_ptr  = (md_g + 1) % N;
        end

        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!tb_idle() && n < 300);
        check({tag, "_idle"}, tb_idle(), 1);
    endtask

    task automatic clear_state();
        for (int m = 0; m < N; m++) begin
            m_aw_pend[m] = 1'b0; m_w_pend[m] = 1'b0; m_wait_b[m] = 1'b0;
            m_aw_dly[m] = 0; m_w_dly[m] = 0; m_brdy_block[m] = 0;
            aw_data[m] = '0; w_data[m] = '0;
        end
        aw_val = '0; w_val = '0; resp_rdy = '1;
        slv.aw_ready = 1'b1; slv.w_ready = 1'b1; slv.b_valid = 1'b0; slv.b_resp = '0;
        s_aw_block = 0; s_w_block = 0; s_b_dly = 0; s_bhs = 1'b0;
        s_aw_seen = 1'b0; s_w_seen = 1'b0; s_resp_next = '0;
        md_busy = 1'b0; md_resp = 1'b0; md_aw_done = 1'b0; md_w_done = 1'b0;
        md_g = 0; md_ptr = 0;
        exp_q.delete();
        grant_log.delete();
    endtask

    // Asynchronous reset: outputs must be quiet before any clock edge.
    task automatic do_reset();
        rstn = 1'b0;
        clear_state();
        #1;
        check("rst_aw_valid", slv.aw_valid, 0);
        check("rst_w_valid", slv.w_valid, 0);
        check("rst_b_ready", slv.b_ready, 0);
        check("rst_aw_rdy", aw_rdy, 0);
        check("rst_w_rdy", w_rdy, 0);
        check("rst_resp_val", resp_val, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_rr_ptr", dut.rr_ptr_q, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- tests ----------------
    initial begin
        int start, base, n;
        int b_tot_before, b_tot_after, aw0, w0;
        bit reissued;
        for (int m = 0; m < N; m++) b_count[m] = 0;
        s_aw_cnt = 0; s_w_cnt = 0; s_b_cnt = 0;
        rstn = 1'b1;
        #2;
        do_reset();

        // single master, minimum latency transaction
        start = cyc;
        new_req(2, 32'h1000_0040, {4'hF, 32'hDEAD_BEEF}, 0, 0);
        wait_idle("t1");
        check("t1_resp_vec", last_resp_vec, 4'b0100);
        check("t1_resp_dat", last_resp_dat, 2'b00);
        check("t1_slv_addr", s_addr, 32'h1000_0040);
        check("t1_slv_wpay", s_wpay, {4'hF, 32'hDEAD_BEEF});
        check("t1_rr_ptr", dut.rr_ptr_q, 3);
        check("t1_latency", s_b_cyc - start, 3);

        // W three cycles ahead of AW
        base = b_count[0];
        b_tot_before = s_b_cnt;
        new_req(0, 32'h0000_1234, {4'h3, 32'h0BAD_F00D}, 3, 0);
        wait_idle("t2");
        check("t2_b_master0", b_count[0] - base, 1);
        check("t2_b_total", s_b_cnt - b_tot_before, 1);
        check("t2_same_cycle", s_w_cyc, s_aw_cyc);

        // contention from reset: 0,1,3 then all four with 0 re-requesting
        do_reset();
        new_req(0, 32'hA000_0000, 36'h1_1111_1111, 0, 0);
        new_req(1, 32'hA000_0001, 36'h2_2222_2222, 0, 0);
        new_req(3, 32'hA000_0003, 36'h3_3333_3333, 0, 0);
        wait_idle("t3a");
        check("t3a_len", grant_log.size(), 3);
        if (grant_log.size() == 3) begin
            check("t3a_g0", grant_log[0], 0);
            check("t3a_g1", grant_log[1], 1);
            check("t3a_g2", grant_log[2], 3);
        end
        grant_log.delete();
        for (int m = 0; m < N; m++) new_req(m, AW'(32'hB000_0000 + m), WW'(m * 7 + 1), 0, 0);
        base = b_count[0];
        reissued = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
            if (!reissued && b_count[0] > base) begin
                new_req(0, 32'hB000_0100, 36'hC_CAFE_0000, 0, 0);
                reissued = 1'b1;
            end
        end while (!(reissued && tb_idle()) && n < 400);
        check("t3b_len", grant_log.size(), 5);
        if (grant_log.size() == 5) begin
            for (int i = 0; i < 5; i++) check("t3b_order", grant_log[i], i % 4);
        end

        // slave AW backpressure, W completes first
        aw0 = s_aw_cnt; w0 = s_w_cnt; b_tot_before = s_b_cnt;
        slv.aw_ready = 1'b0;
        s_aw_block = 5;
        new_req(2, 32'h2000_0080, 36'h5_5555_AAAA, 0, 0);
        wait_idle("t4");
        check("t4_aw_after_w", s_aw_cyc - s_w_cyc, 5);
        check("t4_aw_count", s_aw_cnt - aw0, 1);
        check("t4_w_count", s_w_cnt - w0, 1);
        check("t4_b_count", s_b_cnt - b_tot_before, 1);

        // master B stall with SLVERR
        start = cyc;
        s_resp_next = 2'b10;
        resp_rdy[1] = 1'b0;
        m_brdy_block[1] = 5;
        new_req(1, 32'h3000_0000, 36'hF_0123_4567, 0, 0);
        wait_idle("t5");
        check("t5_b_cycle", s_b_cyc - start, 7);
        check("t5_resp_dat", last_resp_dat, 2'b10);
        check("t5_resp_vec", last_resp_vec, 4'b0010);
        s_resp_next = 2'b00;

        // reset in XFER after the AW handshake, before W
        aw0 = s_aw_cnt; w0 = s_w_cnt;
        new_req(2, 32'h4000_0000, 36'h0_0000_0001, 0, 10);
        n = 0;
        while (s_aw_cnt == aw0 && n < 50) begin
            tick();
            n++;
        end
        check("t6_aw_done", s_aw_cnt - aw0, 1);
        check("t6_w_not_done", s_w_cnt - w0, 0);
        do_reset();
        new_req(0, 32'h5000_0000, 36'h1_0000_0005, 0, 0);
        new_req(3, 32'h5000_0003, 36'h1_0000_0006, 0, 0);
        wait_idle("t6");
        check("t6_len", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            check("t6_first", grant_log[0], 0);
            check("t6_second", grant_log[1], 3);
        end

        // randomized traffic against the model
        b_tot_before = s_b_cnt;
        base = 0;
        for (int m = 0; m < N; m++) base += b_count[m];
        rnd_mode = 1'b1;
        repeat (3000) tick();
        rnd_mode = 1'b0;
        wait_idle("rnd");
        b_tot_after = 0;
        for (int m = 0; m < N; m++) b_tot_after += b_count[m];
        check("rnd_b_balance", b_tot_after - base, s_b_cnt - b_tot_before);
        check("rnd_exp_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
